// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM states and the slice width.
package sub_pkg;
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit subtract cell in carry-chain form: a + ~b + c_in.
module nibble_sub4
    import sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);
    logic [NIBBLE_W:0] total_s;

    // Widen by one bit so the carry out falls into the top bit.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, ~b} + {{NIBBLE_W{1'b0}}, c_in};
        sum     = total_s[NIBBLE_W-1:0];
        c_out   = total_s[NIBBLE_W];
    end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: a - b - borrow_in, one nibble per clock, LSB nibble first,
// with start/done handshake and registered borrow/overflow/zero flags.
module nibble_serial_subtractor
    import sub_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NIBBLE_W*N-1:0] a,
    input  logic [NIBBLE_W*N-1:0] b,
    input  logic                  borrow_in,
    output logic                  busy,
    output logic                  done,
    output logic [NIBBLE_W*N-1:0] diff,
    output logic                  borrow_out,
    output logic                  overflow,
    output logic                  zero
);
    localparam int W     = NIBBLE_W * N;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    state_t               state_r;
    state_t               state_next_s;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic                 c_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 accept_s;
    logic                 last_s;
    logic [NIBBLE_W-1:0]  a_nib_s;
    logic [NIBBLE_W-1:0]  b_nib_s;
    logic [NIBBLE_W-1:0]  sum_s;
    logic                 c_out_s;
    logic [W-1:0]         diff_next_s;

    // A start is taken in DONE as well as IDLE so held-high start gives one result per N+1 cycles.
    always_comb begin
        accept_s = start && ((state_r == IDLE) || (state_r == DONE));
        last_s   = (idx_r == IDX_W'(N - 1));
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            RUN: begin
                if (last_s) state_next_s = DONE;
                else        state_next_s = RUN;
            end
            DONE: begin
                if (start) state_next_s = RUN;
                else       state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= IDLE;
        else       state_r <= state_next_s;
    end

    // Select the current nibble of the latched operands and splice the result into diff.
    always_comb begin
        a_nib_s     = a_r[NIBBLE_W*int'(idx_r) +: NIBBLE_W];
        b_nib_s     = b_r[NIBBLE_W*int'(idx_r) +: NIBBLE_W];
        diff_next_s = diff;
        diff_next_s[NIBBLE_W*int'(idx_r) +: NIBBLE_W] = sum_s;
    end

    nibble_sub4 u_cell (
        .a     (a_nib_s),
        .b     (b_nib_s),
        .c_in  (c_r),
        .sum   (sum_s),
        .c_out (c_out_s)
    );

    // Datapath, status outputs and flags; flags update only on the final nibble.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r        <= '0;
            b_r        <= '0;
            c_r        <= 1'b0;
            idx_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
            zero       <= 1'b0;
        end else begin
            busy <= (state_next_s != IDLE);
            done <= (state_next_s == DONE);
            if (accept_s) begin
                a_r   <= a;
                b_r   <= b;
                c_r   <= ~borrow_in;
                idx_r <= '0;
                diff  <= '0;
            end else if (state_r == RUN) begin
                diff <= diff_next_s;
                c_r  <= c_out_s;
                if (last_s) begin
                    borrow_out <= ~c_out_s;
                    overflow   <= (a_r[W-1] != b_r[W-1]) && (diff_next_s[W-1] != a_r[W-1]);
                    zero       <= (diff_next_s == '0);
                end else begin
                    idx_r <= idx_r + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench: cycle-level behavioural model of the handshake plus literal result checks.
module tb_nibble_serial_subtractor;
    localparam int N = 8;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         borrow_in = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow_out, overflow, zero;
    logic [W-1:0] diff;

    int n_cmp = 0;
    int n_bad = 0;

    nibble_serial_subtractor #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow),
        .zero       (zero)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: m_cnt = 0 idle, 1..N running, N+1 done cycle.
    int           m_cnt = 0;
    logic         m_live = 1'b0;
    logic [W-1:0] m_full = '0;
    logic         m_bfull = 1'b0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_borrow = 1'b0;
    logic         m_ovf = 1'b0;
    logic         m_zero = 1'b0;

    function automatic logic [W-1:0] low_mask(input int k);
        logic [W-1:0] one;
        one = 1;
        if (k >= N) return '1;
        return (one << (4 * k)) - one;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_live   <= 1'b1;
            m_cnt    <= 0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
            m_ovf    <= 1'b0;
            m_zero   <= 1'b0;
        end else if ((m_cnt == 0 || m_cnt == N + 1) && start) begin
            m_cnt             <= 1;
            m_diff            <= '0;
            {m_bfull, m_full} <= {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
            m_a               <= a;
            m_b               <= b;
        end else if (m_cnt >= 1 && m_cnt <= N) begin
            m_diff <= m_full & low_mask(m_cnt);
            if (m_cnt == N) begin
                m_borrow <= m_bfull;
                m_ovf    <= (m_a[W-1] != m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
                m_zero   <= (m_full == '0);
            end
            m_cnt <= m_cnt + 1;
        end else begin
            m_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("busy", W'(busy), W'(m_cnt != 0));
            chk("done", W'(done), W'(m_cnt == N + 1));
            chk("diff", diff, m_diff);
            chk("borrow_out", W'(borrow_out), W'(m_borrow));
            chk("overflow", W'(overflow), W'(m_ovf));
            chk("zero", W'(zero), W'(m_zero));
        end
    end

    // Start one operation, optionally poke start with other operands mid-run, wait for done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic bin,
                          input int poke, input logic lit, input logic [W-1:0] ed,
                          input logic eb, input logic eo, input logic ez);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; borrow_in = bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == poke) begin
                start = 1'b1; a = $urandom; b = $urandom; borrow_in = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", W'(lat), W'(N + 1));
        if (lit) begin
            chk("lit_diff", diff, ed);
            chk("lit_borrow", W'(borrow_out), W'(eb));
            chk("lit_overflow", W'(overflow), W'(eo));
            chk("lit_zero", W'(zero), W'(ez));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        repeat (2) @(negedge clk);
        chk("rst_busy", W'(busy), '0);
        chk("rst_diff", diff, '0);
        reset = 1'b0;

        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 0, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_op(32'hABCD_1234, 32'hABCD_1234, 1'b0, 0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_op(32'h0000_0010, 32'h0000_0001, 1'b1, 0, 1'b1, 32'h0000_000E, 1'b0, 1'b0, 1'b0);
        // start during RUN must be ignored; original result still expected
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 3, 1'b1, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // reset in the middle of an operation
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0000_1111; borrow_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_diff", diff, '0);
        chk("abort_zero", W'(zero), '0);
        reset = 1'b0;
        run_op(32'h1234_5678, 32'h0000_1111, 1'b0, 0, 1'b1, 32'h1234_4567, 1'b0, 1'b0, 1'b0);

        // start held high: one result every N+1 cycles
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (5 * (N + 1)) begin
            a = $urandom; b = $urandom; borrow_in = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        chk("b2b_dones", W'(dones), W'(5));

        repeat (20) begin
            run_op($urandom, $urandom, 1'($urandom_range(0, 1)), 0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
